clk_div_sched: RTL and testbench
================================

// Module: clk_div_sched
// PURPOSE
//  Run-time controller for the 5 MHz-derived acquisition clock.
//  - Syncs the external clk_ref into clk_sys and counts its rising edges.
//  - Generates clk_out, whose half-period is programmable.
//  - Start, stop and ratio changes take effect only at full-period boundaries, so clk_out never glitches.
//  - Sits between the host register file and the NMR pulse/acquisition timing logic.
// PARAMETERS
//  CNT_W        12    half-period counter width
//  DIV_DEFAULT  2500  half-period in ref edges after reset (5 MHz ref -> 1 kHz)
//  BURST_W      16    burst length width (CLK_DIV_BURST_EN only)
// PORTS
//  clk_sys    in   1        system clock
//  rst_n      in   1        reset, synchronous, active-low
//  clk_ref    in   1        asynchronous 5 MHz reference
//  cfg_div    in   CNT_W    requested half-period, in ref edges
//  cfg_valid  in   1        cfg_div offer
//  cfg_ready  out  1        cfg_div accepted when cfg_valid & cfg_ready
//  start      in   1        1-cycle pulse: begin generation
//  stop       in   1        1-cycle pulse: stop at next period end
//  burst_len  in   BURST_W  full periods per run, 0 = continuous (macro only)
//  clk_out    out  1        divided clock, registered
//  tick       out  1        1-cycle pulse on each clk_out 0->1
//  busy       out  1        high in RUN and STOP_PEND
//  done       out  1        1-cycle pulse on return to IDLE
// BEHAVIOUR
//  Reset values: clk_out=0, tick=0, busy=0, done=0, cfg_ready=1, count=1, div_act=DIV_DEFAULT, no config pending, state IDLE.
//  Reference edge detection:
//  - ref_en = r1 & ~r2, from a 2-flop synchroniser on clk_ref.
//  - clk_out toggles on the clk_sys edge where ref_en=1 and count==div_act. That edge also reloads count=1.
//  - Other ref_en edges: count+1. No ref_en: hold.
//  - Latency from clk_ref rise to clk_out change is 3 clk_sys cycles.
//  Divide ratio:
//  - cfg_div=0 is treated as 1.
//  - Output period = 2*div_act ref edges.
//  States:
//  - IDLE: on start, go to RUN with clk_out=0, count=1.
//  - RUN: on stop, go to STOP_PEND. A start seen in RUN is ignored.
//  - STOP_PEND: at the next clk_out 1->0, go to IDLE and pulse done.
//  - start and stop in the same cycle: stop wins; from IDLE, stay in IDLE.
//  Period boundary: the clk_out 1->0 toggle.
//  Config handshake:
//  - In IDLE, an accepted cfg_div loads div_act on the next cycle.
//  - In RUN, an accepted cfg_div is held pending and copied to div_act at the next period boundary. count restarts at 1.
//  - cfg_ready=0 while a config is pending. A second offer stalls until the pending one is applied.
//  - A pending config is still applied if the block goes to IDLE.
//  Reset mid-run forces all reset values at once. clk_out may be truncated.
//  The counter never wraps: reload happens at count==div_act, and div_act <= 2^CNT_W-1.
// CONFIGURATION
//  CLK_DIV_BURST_EN defined:
//  - burst_len is sampled on start.
//  - Nonzero: after burst_len period boundaries, go to IDLE and pulse done.
//  - stop still ends the run early at the next boundary.
//  CLK_DIV_BURST_EN undefined:
//  - burst_len port is absent.
//  - Runs are continuous until stop.
// STRUCTURE
//  clk_div_pkg: state encoding (IDLE, RUN, STOP_PEND) and the DIV_DEFAULT constant.
//  Sub-module ref_edge_det: 2-flop synchroniser plus rising-edge pulse, outputs ref_en.
//  Top level: counter, state machine and config/burst registers.
// TESTING
//  1. Reset, start, clk_ref=5 MHz -> clk_out period 5000 ref edges (1 kHz), 50% duty, first tick after 2500 edges.
//  2. cfg_div=3 while running -> clk_out keeps old ratio until the next 1->0 toggle, then period is 6 edges.
//     A second cfg_valid during that time sees cfg_ready=0.
//  3. stop mid-high-phase -> clk_out completes the phase. done pulses 1 cycle at the 1->0 toggle. busy=0 the same cycle.
//  4. start+stop in the same cycle from IDLE -> busy stays 0, clk_out stays 0.
//  5. Reset asserted mid-run with clk_out=1 -> next cycle clk_out=0, busy=0, cfg_ready=1, div_act=2500.
//  6. CLK_DIV_BURST_EN, burst_len=4, cfg_div=2 -> exactly 4 tick pulses, then done after 16 ref edges.
//     burst_len=0 -> runs until stop.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the acquisition clock divider/scheduler.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    // Half-period after reset: 5 MHz ref / (2 * 2500) = 1 kHz.
    localparam int DIV_DEFAULT = 2500;

endpackage

// File: rtl/ref_edge_det.sv
// Synchronises the asynchronous reference into clk_sys and emits a one-cycle
// pulse per rising edge. Rise-to-pulse is two clk_sys edges.
module ref_edge_det (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic clk_ref,
    output logic ref_en
);

    logic r0_q, r0_d;
    logic r1_q, r1_d;
    logic r2_q, r2_d;

    always_comb begin
        r0_d = clk_ref;
        r1_d = r0_q;
        r2_d = r1_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r0_q <= 1'b0;
            r1_q <= 1'b0;
            r2_q <= 1'b0;
        end else begin
            r0_q <= r0_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
        end
    end

    assign ref_en = r1_q & ~r2_q;

endmodule

// File: rtl/clk_div_sched.sv
// Glitch-free programmable divider of clk_ref with start/stop/ratio changes at period ends.
// Optional burst mode (fixed number of periods per run) under `CLK_DIV_BURST_EN.
module clk_div_sched #(
    parameter int CNT_W       = 12,
`ifdef CLK_DIV_BURST_EN
    parameter int BURST_W     = 16,
`endif
    parameter int DIV_DEFAULT = clk_div_pkg::DIV_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             clk_ref,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
`ifdef CLK_DIV_BURST_EN
    input  logic [BURST_W-1:0] burst_len,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    import clk_div_pkg::*;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ref_en;
    logic             running, hit, rise, fall, cfg_acc, burst_end;
    logic [CNT_W-1:0] cfg_div_sat;

    ref_edge_det u_ref_edge_det (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clk_ref (clk_ref),
        .ref_en  (ref_en)
    );

    assign running     = (state_q != IDLE);
    assign hit         = running && ref_en && (count_q == div_act_q);
    assign rise        = hit && !clk_out_q;
    assign fall        = hit && clk_out_q;
    assign cfg_acc     = cfg_valid && !pend_q;
    assign cfg_div_sat = (cfg_div == '0) ? CNT_W'(1) : cfg_div;

`ifdef CLK_DIV_BURST_EN
    logic [BURST_W-1:0] burst_len_q, burst_len_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    assign burst_end = fall && (burst_len_q != '0)
                       && ((burst_cnt_q + BURST_W'(1)) == burst_len_q);

    always_comb begin
        burst_len_d = burst_len_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == IDLE && start && !stop) begin
            burst_len_d = burst_len;
            burst_cnt_d = '0;
        end else if (fall) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            burst_len_q <= '0;
            burst_cnt_q <= '0;
        end else begin
            burst_len_q <= burst_len_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign burst_end = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        clk_out_d  = clk_out_q;
        div_act_d  = div_act_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;

        if (running && ref_en) begin
            if (hit) begin
                count_d   = CNT_W'(1);
                clk_out_d = !clk_out_q;
            end else begin
                count_d   = count_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = RUN;
                    count_d   = CNT_W'(1);
                    clk_out_d = 1'b0;
                end
            end
            RUN: begin
                if (burst_end)  state_d = IDLE;
                else if (stop)  state_d = STOP_PEND;
            end
            STOP_PEND: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pending ratio lands on the falling edge, including the one that ends the run.
        if (fall && pend_q) begin
            div_act_d = pend_div_q;
            pend_d    = 1'b0;
        end
        if (cfg_acc) begin
            if (state_q == IDLE) begin
                div_act_d = cfg_div_sat;
            end else begin
                pend_d     = 1'b1;
                pend_div_d = cfg_div_sat;
            end
        end

        tick_d = rise;
        busy_d = (state_d != IDLE);
        done_d = running && (state_d == IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= CNT_W'(1);
            div_act_q  <= CNT_W'(DIV_DEFAULT);
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            div_act_q  <= div_act_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: expected rise/fall/done events tagged with
// the reference edge number they must occur on; a negedge monitor pops and compares.
module tb_clk_div_sched;

    localparam int CNT_W = 12;

    typedef enum int {EV_RISE = 0, EV_FALL = 1, EV_DONE = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       edge_n;
    } ev_t;

    logic             clk_sys = 1'b0;
    logic             clk_ref = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             start;
    logic             stop;
`ifdef CLK_DIV_BURST_EN
    logic [15:0]      burst_len;
`endif
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             done;

    ev_t exp_q[$];
    int  total   = 0;
    int  bad     = 0;
    int  ref_cnt = 0;
    int  base;
    bit  in_rst  = 1'b1;
    logic prev_out = 1'b0;

    clk_div_sched dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .clk_ref   (clk_ref),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .start     (start),
        .stop      (stop),
`ifdef CLK_DIV_BURST_EN
        .burst_len (burst_len),
`endif
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_sys = ~clk_sys;
    initial begin
        #2;
        forever #40 clk_ref = ~clk_ref;
    end
    always @(posedge clk_ref) ref_cnt = ref_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_chk(input ev_kind_t k, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s unexpected: got edge %0d expected no event", name, ref_cnt);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, k, e.kind);
            chk({name, "_edge"}, ref_cnt, e.edge_n);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!in_rst) begin
            if (clk_out && !prev_out) begin
                pop_chk(EV_RISE, "rise");
                chk("tick_at_rise", tick, 1);
            end else if (!clk_out && prev_out) begin
                pop_chk(EV_FALL, "fall");
            end
            if (tick && !(clk_out && !prev_out)) chk("stray_tick", tick, 0);
            if (done) begin
                pop_chk(EV_DONE, "done");
                chk("busy_at_done", busy, 0);
            end
        end
        prev_out = clk_out;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Return mid ref period so the next counted edge is ref_cnt+1.
    task automatic align();
        @(posedge clk_ref);
        repeat (4) @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input ev_kind_t k, input int e);
        ev_t ev;
        ev.kind   = k;
        ev.edge_n = e;
        exp_q.push_back(ev);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic set_cfg(input int v);
        cfg_div   = CNT_W'(v);
        cfg_valid = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            cyc(1);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: got %0d events left expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_div   = '0;
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
`ifdef CLK_DIV_BURST_EN
        burst_len = '0;
`endif
        cyc(4);
        rst_n = 1'b1;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_div_act", dut.div_act_q, 2500);
        chk("rst_count", dut.count_q, 1);
        in_rst = 1'b0;

        // Default ratio: rise after 2500 edges, fall after 5000.
        align();
        base = ref_cnt;
        pulse_start();
        chk("t1_busy", busy, 1);
        push(EV_RISE, base + 2500);
        wait_empty("t1_rise", 2600 * 8);
        push(EV_FALL, base + 5000);

        // Ratio change in the high phase is held until the falling edge.
        chk("t2_ready_first", cfg_ready, 1);
        set_cfg(3);
        chk("t2_ready_pend", cfg_ready, 0);
        cfg_div   = CNT_W'(7);
        cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t2_ready_stall", cfg_ready, 0);
        end
        cfg_valid = 1'b0;
        chk("t2_div_held", dut.div_act_q, 2500);
        push(EV_RISE, base + 5003);
        push(EV_FALL, base + 5006);
        push(EV_RISE, base + 5009);
        wait_empty("t2_new_ratio", 2600 * 8);
        chk("t2_div_applied", dut.div_act_q, 3);
        chk("t2_ready_back", cfg_ready, 1);

        // Stop in the high phase finishes the phase, done on the falling edge.
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t3_busy_pend", busy, 1);
        chk("t3_clk_high", clk_out, 1);
        push(EV_FALL, base + 5012);
        push(EV_DONE, base + 5012);
        wait_empty("t3_stop", 200);
        cyc(2);
        chk("t3_busy_idle", busy, 0);

        // Start and stop together from IDLE: nothing happens.
        align();
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(8);
            chk("t4_busy", busy, 0);
            chk("t4_clk_out", clk_out, 0);
        end

        // cfg_div=0 maps to 1; then reset in the middle of a high phase.
        set_cfg(0);
        chk("t5_div_zero", dut.div_act_q, 1);
        set_cfg(5);
        chk("t5_div_idle", dut.div_act_q, 5);
        align();
        base = ref_cnt;
        pulse_start();
        push(EV_RISE, base + 5);
        wait_empty("t5_rise", 200);
        chk("t5_clk_high", clk_out, 1);
        in_rst = 1'b1;
        rst_n  = 1'b0;
        cyc(1);
        chk("t5_clk_out", clk_out, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cfg_ready", cfg_ready, 1);
        chk("t5_tick", tick, 0);
        chk("t5_div_act", dut.div_act_q, 2500);
        rst_n = 1'b1;
        cyc(2);
        in_rst = 1'b0;

`ifdef CLK_DIV_BURST_EN
        // Burst of 4 periods at half-period 2: done after 16 edges.
        set_cfg(2);
        burst_len = 16'd4;
        align();
        base = ref_cnt;
        pulse_start();
        burst_len = 16'd0;
        for (int k = 0; k < 4; k++) begin
            push(EV_RISE, base + 4 * k + 2);
            push(EV_FALL, base + 4 * k + 4);
        end
        push(EV_DONE, base + 16);
        wait_empty("t6_burst", 400);
        cyc(2);
        chk("t6_busy_idle", busy, 0);

        // burst_len=0 keeps running past 4 periods until stop.
        align();
        base = ref_cnt;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            push(EV_RISE, base + 4 * k + 2);
            push(EV_FALL, base + 4 * k + 4);
        end
        push(EV_RISE, base + 22);
        wait_empty("t6_cont", 400);
        chk("t6_busy_cont", busy, 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        push(EV_FALL, base + 24);
        push(EV_DONE, base + 24);
        wait_empty("t6_stop", 200);
`endif

        cyc(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
